removal_sweep_ctrl: RTL and testbench

// Sequencer around the combinational remove_accessible sweep. It loads a WIDTH x DEPTH paper grid
// (1 = paper) row by row into an internal register, then applies one sweep per clock until a sweep

---
 rtl/removal_sweep_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_removal_sweep_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/removal_sweep_ctrl.sv
// Load / sweep / done sequencer around the remove_accessible sweep on a WIDTH x DEPTH paper grid.
// Optional SWEEP_STAT_EN macro adds per-sweep statistics outputs (sweep_valid, sweep_removed).
module removal_sweep_ctrl #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int MAX_ITER = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                load_valid,
    input  logic [WIDTH-1:0]                    load_row,
    output logic                                load_ready,
    output logic                                busy,
    output logic                                done,
    output logic                                timeout,
    output logic [$clog2(WIDTH*DEPTH+1)-1:0]    total_removed,
    output logic [$clog2(MAX_ITER+1)-1:0]       iter_count,
    input  logic [$clog2(DEPTH)-1:0]            rd_addr,
`ifdef SWEEP_STAT_EN
    output logic                                sweep_valid,
    output logic [$clog2(WIDTH*DEPTH+1)-1:0]    sweep_removed,
`endif
    output logic [WIDTH-1:0]                    rd_row
);

    localparam int CW = $clog2(WIDTH*DEPTH+1);
    localparam int IW = $clog2(MAX_ITER+1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SWEEP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [DEPTH-1:0][WIDTH-1:0]   grid;
    logic [DEPTH-1:0][WIDTH-1:0]   mat_out;
    logic [AW-1:0]                 ptr;
    logic [CW-1:0]                 removed;
    logic                          any_removed;
    logic                          last_row;
    logic                          last_iter;

    // A cell is accessible when fewer than four of its eight neighbours hold paper
    function automatic logic [3:0] nbr_count(input logic [DEPTH-1:0][WIDTH-1:0] g,
                                             input int r, input int c);
        logic [3:0] n;
        n = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < DEPTH) &&
                    (c + dc >= 0) && (c + dc < WIDTH) && g[r+dr][c+dc]) begin
                    n = n + 4'd1;
                end else begin
                    n = n;
                end
            end
        end
        return n;
    endfunction

    assign last_row  = (ptr == AW'(DEPTH - 1));
    assign last_iter = (iter_count == IW'(MAX_ITER - 1));
    assign rd_row    = grid[rd_addr];

    // One combinational sweep of the registered grid
    always_comb begin
        mat_out = grid;
        removed = '0;
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                if (grid[r][c] && (nbr_count(grid, r, c) < 4'd4)) begin
                    mat_out[r][c] = 1'b0;
                    removed       = removed + CW'(1'b1);
                end else begin
                    mat_out[r][c] = grid[r][c];
                end
            end
        end
        any_removed = (removed != '0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
                else       state_nxt = S_IDLE;
            end
            S_LOAD: begin
                if (load_valid && last_row) state_nxt = S_SWEEP;
                else                        state_nxt = S_LOAD;
            end
            S_SWEEP: begin
                if (!any_removed || last_iter) state_nxt = S_DONE;
                else                           state_nxt = S_SWEEP;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b1;
            end
            S_SWEEP: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                load_ready = 1'b0;
                busy       = 1'b0;
                done       = 1'b0;
            end
        endcase
    end

    // Grid, row pointer and job result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grid          <= '0;
            ptr           <= '0;
            total_removed <= '0;
            iter_count    <= '0;
            timeout       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr           <= '0;
                        total_removed <= '0;
                        iter_count    <= '0;
                        timeout       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        grid[ptr] <= load_row;
                        ptr       <= ptr + AW'(1'b1);
                    end
                end
                S_SWEEP: begin
                    if (any_removed) begin
                        grid          <= mat_out;
                        total_removed <= total_removed + removed;
                        iter_count    <= iter_count + IW'(1'b1);
                        if (last_iter) timeout <= 1'b1;
                    end
                end
                default: begin
                    grid <= grid;
                end
            endcase
        end
    end

`ifdef SWEEP_STAT_EN
    // Per-sweep statistics, valid in every SWEEP cycle including the final empty one
    always_comb begin
        if (state == S_SWEEP) begin
            sweep_valid   = 1'b1;
            sweep_removed = removed;
        end else begin
            sweep_valid   = 1'b0;
            sweep_removed = '0;
        end
    end
`endif

endmodule

// File: tb/tb_removal_sweep_ctrl.sv
// Randomised bench for removal_sweep_ctrl: two instances (MAX_ITER 255 and 2) fed identical jobs
// and compared against a cell-array reference model of the sweep rule.
module tb_removal_sweep_ctrl;
    localparam int W = 16;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst, start, load_valid;
    logic [15:0] load_row;
    logic [3:0]  rd_addr;
    logic        load_ready_a, busy_a, done_a, timeout_a;
    logic        load_ready_b, busy_b, done_b, timeout_b;
    logic [8:0]  total_a, total_b;
    logic [7:0]  iter_a;
    logic [1:0]  iter_b;
    logic [15:0] rd_row_a, rd_row_b;
`ifdef SWEEP_STAT_EN
    logic        sv_a, sv_b;
    logic [8:0]  sr_a, sr_b;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] job_rows[D];
    logic [15:0] exp_rows[2][D];
    int          exp_tot[2];
    int          exp_it[2];
    int          exp_to[2];
    int          exp_sw[2];
    int          exp_sweeps[$];

    always #5 clk = ~clk;

    removal_sweep_ctrl #(.WIDTH(W), .DEPTH(D), .MAX_ITER(255)) dut_a (
        .clk(clk), .rst(rst), .start(start), .load_valid(load_valid), .load_row(load_row),
        .load_ready(load_ready_a), .busy(busy_a), .done(done_a), .timeout(timeout_a),
        .total_removed(total_a), .iter_count(iter_a), .rd_addr(rd_addr),
`ifdef SWEEP_STAT_EN
        .sweep_valid(sv_a), .sweep_removed(sr_a),
`endif
        .rd_row(rd_row_a)
    );

    removal_sweep_ctrl #(.WIDTH(W), .DEPTH(D), .MAX_ITER(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .load_valid(load_valid), .load_row(load_row),
        .load_ready(load_ready_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
        .total_removed(total_b), .iter_count(iter_b), .rd_addr(rd_addr),
`ifdef SWEEP_STAT_EN
        .sweep_valid(sv_b), .sweep_removed(sr_b),
`endif
        .rd_row(rd_row_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference: repeatedly remove every paper cell with fewer than four paper neighbours
    task automatic model(input int k, input int max_iter);
        int g[D][W];
        int rm[D][W];
        int n, cnt, tot, it, to, rr, cc;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < W; c++)
                g[r][c] = int'(job_rows[r][c]);
        tot = 0; it = 0; to = 0;
        if (k == 0) exp_sweeps.delete();
        while (1) begin
            n = 0;
            for (int r = 0; r < D; r++) begin
                for (int c = 0; c < W; c++) begin
                    rm[r][c] = 0;
                    if (g[r][c] == 1) begin
                        cnt = 0;
                        for (int dr = -1; dr <= 1; dr++)
                            for (int dc = -1; dc <= 1; dc++) begin
                                rr = r + dr; cc = c + dc;
                                if (!(dr == 0 && dc == 0) && rr >= 0 && rr < D && cc >= 0 && cc < W)
                                    cnt += g[rr][cc];
                            end
                        if (cnt < 4) begin
                            rm[r][c] = 1;
                            n++;
                        end
                    end
                end
            end
            if (k == 0) exp_sweeps.push_back(n);
            if (n == 0) break;
            for (int r = 0; r < D; r++)
                for (int c = 0; c < W; c++)
                    if (rm[r][c] == 1) g[r][c] = 0;
            tot += n;
            it++;
            if (it == max_iter) begin
                to = 1;
                break;
            end
        end
        exp_tot[k] = tot;
        exp_it[k]  = it;
        exp_to[k]  = to;
        exp_sw[k]  = (to == 1) ? it : it + 1;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < W; c++)
                exp_rows[k][r][c] = (g[r][c] == 1) ? 1'b1 : 1'b0;
    endtask

    task automatic read_row(input int addr);
        rd_addr = 4'(addr);
        #1;
    endtask

    task automatic run_job(input string name, input int stall_pct, input bit poke_start);
        int acc, stalls, edges, sv_idx;
        int done_edge[2];
        int done_cnt[2];
        bit stalled;
        model(0, 255);
        model(1, 2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, ".load_ready"}, 32'(load_ready_a), 32'd1);
        acc = 0; stalls = 0; edges = 0; sv_idx = 0;
        while (acc < D) begin
            if (int'($urandom_range(99)) < stall_pct) begin
                load_valid = 1'b0; load_row = 16'($urandom); stalled = 1'b1;
            end else begin
                load_valid = 1'b1; load_row = job_rows[acc]; stalled = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
            if (stalled) stalls++;
            else acc++;
        end
        load_valid = 1'b0;
        check({name, ".busy_sweep"}, 32'(busy_a), 32'd1);
        done_edge[0] = -1; done_edge[1] = -1;
        done_cnt[0] = 0;   done_cnt[1] = 0;
        for (int k = 0; k < 600; k++) begin
            start = (poke_start && k == 0) ? 1'b1 : 1'b0;
`ifdef SWEEP_STAT_EN
            if (sv_a) begin
                if (sv_idx < exp_sweeps.size())
                    check({name, ".sweep_removed"}, 32'(sr_a), 32'(exp_sweeps[sv_idx]));
                else
                    check({name, ".sweep_extra"}, 32'(sv_idx), 32'(exp_sweeps.size()));
                sv_idx++;
            end
`endif
            @(posedge clk); #1;
            edges++;
            if (done_a) begin done_cnt[0]++; done_edge[0] = edges; end
            if (done_b) begin done_cnt[1]++; done_edge[1] = edges; end
            if (done_cnt[0] > 0 && done_cnt[1] > 0 &&
                edges > done_edge[0] + 2 && edges > done_edge[1] + 2) break;
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s.done_count%0d", name, k), 32'(done_cnt[k]), 32'd1);
            // cycles counted inclusively from the start cycle through the done cycle
            check($sformatf("%s.latency%0d", name, k), 32'(done_edge[k] + 2),
                  32'(1 + D + stalls + exp_sw[k] + 1));
        end
`ifdef SWEEP_STAT_EN
        check({name, ".sweep_pulses"}, 32'(sv_idx), 32'(exp_sweeps.size()));
`endif
        check({name, ".total_a"},   32'(total_a),   32'(exp_tot[0]));
        check({name, ".iter_a"},    32'(iter_a),    32'(exp_it[0]));
        check({name, ".timeout_a"}, 32'(timeout_a), 32'(exp_to[0]));
        check({name, ".total_b"},   32'(total_b),   32'(exp_tot[1]));
        check({name, ".iter_b"},    32'(iter_b),    32'(exp_it[1]));
        check({name, ".timeout_b"}, 32'(timeout_b), 32'(exp_to[1]));
        check({name, ".busy_idle"}, 32'(busy_a),    32'd0);
        for (int r = 0; r < D; r++) begin
            read_row(r);
            check($sformatf("%s.row_a%0d", name, r), 32'(rd_row_a), 32'(exp_rows[0][r]));
            check($sformatf("%s.row_b%0d", name, r), 32'(rd_row_b), 32'(exp_rows[1][r]));
        end
    endtask

    task automatic set_block();
        for (int r = 0; r < D; r++) job_rows[r] = 16'h0000;
        for (int r = 4; r <= 6; r++) job_rows[r] = 16'h0070;
    endtask

    initial begin
        int dens;
        rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_row = 16'h0000; rd_addr = 4'd0;
        #12;
        check("reset.busy",    32'(busy_a),       32'd0);
        check("reset.done",    32'(done_a),       32'd0);
        check("reset.ready",   32'(load_ready_a), 32'd0);
        check("reset.total",   32'(total_a),      32'd0);
        check("reset.iter",    32'(iter_a),       32'd0);
        check("reset.timeout", 32'(timeout_a),    32'd0);
        check("reset.row0",    32'(rd_row_a),     32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < D; r++) job_rows[r] = 16'h0000;
        run_job("t1_zero", 0, 1'b0);
        check("t1.total", 32'(total_a), 32'd0);
        check("t1.iter",  32'(iter_a),  32'd0);

        job_rows[5] = 16'h0020;
        run_job("t2_single", 0, 1'b0);
        read_row(5);
        check("t2.row5",  32'(rd_row_a), 32'h0000);
        check("t2.total", 32'(total_a),  32'd1);

        for (int r = 0; r < D; r++) job_rows[r] = 16'hFFFF;
        run_job("t3_full", 0, 1'b0);
        check("t3.total", 32'(total_a), 32'd4);
        check("t3.iter",  32'(iter_a),  32'd1);
        read_row(0);  check("t3.row0",  32'(rd_row_a), 32'h7FFE);
        read_row(15); check("t3.row15", 32'(rd_row_a), 32'h7FFE);
        read_row(1);  check("t3.row1",  32'(rd_row_a), 32'hFFFF);

        set_block();
        run_job("t4_block", 0, 1'b0);
        check("t4.total",     32'(total_a),   32'd9);
        check("t4.iter",      32'(iter_a),    32'd3);
        check("t4.timeout",   32'(timeout_a), 32'd0);
        check("t5.total",     32'(total_b),   32'd8);
        check("t5.iter",      32'(iter_b),    32'd2);
        check("t5.timeout",   32'(timeout_b), 32'd1);
        read_row(5);
        check("t5.row5_bit5", 32'(rd_row_b[5]), 32'd1);

        set_block();
        run_job("t6_stall_poke", 50, 1'b1);

        // abort a job in its second sweep cycle with reset
        set_block();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        load_valid = 1'b1;
        for (int r = 0; r < D; r++) begin
            load_row = job_rows[r];
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        @(posedge clk); #1;
        check("t6.busy_before_rst", 32'(busy_a), 32'd1);
        rst = 1'b1;
        rd_addr = 4'd5;
        #1;
        check("t6.rst_busy",  32'(busy_a),    32'd0);
        check("t6.rst_done",  32'(done_a),    32'd0);
        check("t6.rst_total", 32'(total_a),   32'd0);
        check("t6.rst_iter",  32'(iter_a),    32'd0);
        check("t6.rst_tmo",   32'(timeout_b), 32'd0);
        check("t6.rst_row5",  32'(rd_row_a),  32'd0);
        #3 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("t6.no_done", 32'(done_a | done_b), 32'd0);
        end
        run_job("t6_after_rst", 0, 1'b0);

        for (int j = 0; j < 8; j++) begin
            dens = 20 + 10 * int'($urandom_range(7));
            for (int r = 0; r < D; r++)
                for (int c = 0; c < W; c++)
                    job_rows[r][c] = (int'($urandom_range(99)) < dens) ? 1'b1 : 1'b0;
            run_job($sformatf("rand%0d", j), int'($urandom_range(40)), j[0]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
